// File: rtl/bsg_zynq_axil_fifo_arbiter.sv
// Two-requester arbiter in front of one bsg_axil_fifo_master command/response port.
// Commands are granted round-robin and the grant is held while the master stalls.
// A tag FIFO remembers which requester issued each command, so every response
// (read data or write acknowledge) goes back to the requester that issued it.
//
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   req_*_i / req_ready_and_o   per-requester command channel (slice i = requester i)
//   resp_data_o / resp_v_o /
//   resp_ready_and_i            per-requester response channel (data shared)
//   m_*_o / m_ready_and_i       command channel to fifo_master
//   m_data_i / m_v_i /
//   m_ready_and_o               response channel from fifo_master
//   outstanding_o               issued-but-unanswered command count
//   error_o                     sticky protocol error
module bsg_zynq_axil_fifo_arbiter #(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned els_p        = 4,
  localparam int unsigned MaskW       = data_width_p / 8,
  localparam int unsigned CntW        = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [1:0]                req_v_i,
  input  logic [1:0]                req_w_i,
  input  logic [2*addr_width_p-1:0] req_addr_i,
  input  logic [2*data_width_p-1:0] req_data_i,
  input  logic [2*MaskW-1:0]        req_wmask_i,
  output logic [1:0]                req_ready_and_o,
  output logic [data_width_p-1:0]   resp_data_o,
  output logic [1:0]                resp_v_o,
  input  logic [1:0]                resp_ready_and_i,
  output logic                      m_v_o,
  output logic                      m_w_o,
  output logic [addr_width_p-1:0]   m_addr_o,
  output logic [data_width_p-1:0]   m_data_o,
  output logic [MaskW-1:0]          m_wmask_o,
  input  logic                      m_ready_and_i,
  input  logic [data_width_p-1:0]   m_data_i,
  input  logic                      m_v_i,
  output logic                      m_ready_and_o,
  output logic [CntW-1:0]           outstanding_o,
  output logic                      error_o
);

  localparam int unsigned PtrW = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(els_p - 1);

  logic            last_q, last_d;
  logic            lock_v_q, lock_v_d;
  logic            lock_id_q, lock_id_d;
  logic            error_q, error_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            tag_q [els_p];
  logic            tag_d [els_p];

  logic grant, full, empty, head, push, pop, cmd_rdy;

  assign full  = (cnt_q == CntW'(els_p));
  assign empty = (cnt_q == '0);
  assign head  = tag_q[rd_ptr_q];

  // A held grant wins over round-robin; otherwise alternate on contention.
  always_comb begin
    if (lock_v_q)          grant = lock_id_q;
    else if (&req_v_i)     grant = ~last_q;
    else                   grant = req_v_i[1];
  end

  // Command path: purely combinational, no added latency.
  assign cmd_rdy         = m_ready_and_i & ~full;
  assign m_v_o           = req_v_i[grant] & ~full;
  assign m_w_o           = req_w_i[grant];
  assign m_addr_o        = grant ? req_addr_i[2*addr_width_p-1:addr_width_p]
                                 : req_addr_i[addr_width_p-1:0];
  assign m_data_o        = grant ? req_data_i[2*data_width_p-1:data_width_p]
                                 : req_data_i[data_width_p-1:0];
  assign m_wmask_o       = grant ? req_wmask_i[2*MaskW-1:MaskW] : req_wmask_i[MaskW-1:0];
  assign req_ready_and_o = grant ? {cmd_rdy, 1'b0} : {1'b0, cmd_rdy};
  assign push            = m_v_o & m_ready_and_i;

  // Response path: routed by the oldest tag; untagged responses are never consumed.
  assign resp_data_o   = m_data_i;
  assign resp_v_o      = head ? {m_v_i & ~empty, 1'b0} : {1'b0, m_v_i & ~empty};
  assign m_ready_and_o = resp_ready_and_i[head] & ~empty;
  assign pop           = m_v_i & m_ready_and_o;

  assign outstanding_o = cnt_q;
  assign error_o       = error_q;

  always_comb begin
    last_d    = last_q;
    lock_v_d  = lock_v_q;
    lock_id_d = lock_id_q;
    error_d   = error_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_d     = tag_q;

    if (push) begin
      lock_v_d = 1'b0;
    end else if (lock_v_q && !req_v_i[lock_id_q]) begin
      // Locked requester withdrew its command before acceptance.
      lock_v_d = 1'b0;
      error_d  = 1'b1;
    end else if (m_v_o && !m_ready_and_i) begin
      lock_v_d  = 1'b1;
      lock_id_d = grant;
    end

    if (m_v_i && empty) error_d = 1'b1;

    if (push) begin
      last_d          = grant;
      tag_d[wr_ptr_q] = grant;
      wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_q    <= 1'b1;
      lock_v_q  <= 1'b0;
      lock_id_q <= 1'b0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < int'(els_p); i++) tag_q[i] <= 1'b0;
    end else begin
      last_q    <= last_d;
      lock_v_q  <= lock_v_d;
      lock_id_q <= lock_id_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tag_q     <= tag_d;
    end
  end

endmodule

// File: tb/tb_bsg_zynq_axil_fifo_arbiter.sv
// Directed bench for bsg_zynq_axil_fifo_arbiter (els_p = 4). Inputs change on the
// falling edge; combinational outputs are checked 1 time unit later and registered
// state 1 time unit after the rising edge.
module tb_bsg_zynq_axil_fifo_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [1:0]  req_v_i, req_w_i, req_ready_and_o, resp_v_o, resp_ready_and_i;
  logic [63:0] req_addr_i, req_data_i;
  logic [7:0]  req_wmask_i;
  logic [31:0] resp_data_o, m_addr_o, m_data_o, m_data_i;
  logic        m_v_o, m_w_o, m_ready_and_i, m_v_i, m_ready_and_o, error_o;
  logic [3:0]  m_wmask_o;
  logic [2:0]  outstanding_o;

  int total = 0;
  int bad   = 0;

  bsg_zynq_axil_fifo_arbiter #(
    .data_width_p(32), .addr_width_p(32), .els_p(4)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_w_i(req_w_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_wmask_i(req_wmask_i), .req_ready_and_o(req_ready_and_o),
    .resp_data_o(resp_data_o), .resp_v_o(resp_v_o), .resp_ready_and_i(resp_ready_and_i),
    .m_v_o(m_v_o), .m_w_o(m_w_o), .m_addr_o(m_addr_o), .m_data_o(m_data_o),
    .m_wmask_o(m_wmask_o), .m_ready_and_i(m_ready_and_i), .m_data_i(m_data_i),
    .m_v_i(m_v_i), .m_ready_and_o(m_ready_and_o), .outstanding_o(outstanding_o),
    .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    req_v_i = 2'b00; req_w_i = 2'b10; m_ready_and_i = 1'b0; m_v_i = 1'b0;
    m_data_i = '0; resp_ready_and_i = 2'b11;
    req_addr_i = {32'h0000_0200, 32'h0000_0100};
    req_data_i = {32'hBBBB_0001, 32'hAAAA_0000};
    req_wmask_i = 8'hF3;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    reset_n_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", outstanding_o); end
    total++; if (error_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", error_o); end
    total++; if ({m_v_o, m_ready_and_o, resp_v_o} !== 4'b0000) begin bad++; $display("FAIL reset_valids got=%b exp=0000", {m_v_o, m_ready_and_o, resp_v_o}); end
  endtask

  task automatic test_single_read();
    do_reset();
    req_v_i = 2'b01; req_addr_i[31:0] = 32'h8; m_ready_and_i = 1'b1;
    #1;
    total++; if ({m_v_o, m_addr_o, req_ready_and_o} !== {1'b1, 32'h8, 2'b01}) begin bad++; $display("FAIL rd_cmd got v=%b a=%h r=%b exp v=1 a=8 r=01", m_v_o, m_addr_o, req_ready_and_o); end
    total++; if ({m_w_o, m_data_o, m_wmask_o} !== {1'b0, 32'hAAAA_0000, 4'h3}) begin bad++; $display("FAIL rd_payload got w=%b d=%h m=%h", m_w_o, m_data_o, m_wmask_o); end
    @(posedge clk_i); #1;
    total++; if (outstanding_o !== 3'd1) begin bad++; $display("FAIL rd_cnt1 got=%0d exp=1", outstanding_o); end
    @(negedge clk_i);
    req_v_i = 2'b00; m_v_i = 1'b1; m_data_i = 32'h1;
    #1;
    total++; if ({resp_v_o, resp_data_o, m_ready_and_o} !== {2'b01, 32'h1, 1'b1}) begin bad++; $display("FAIL rd_resp got v=%b d=%h r=%b exp v=01 d=1 r=1", resp_v_o, resp_data_o, m_ready_and_o); end
    @(posedge clk_i); #1;
    total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL rd_cnt0 got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_contention();
    logic [31:0] exp_a [4];
    logic [1:0]  exp_v [4];
    exp_a[0] = 32'h100; exp_a[1] = 32'h200; exp_a[2] = 32'h100; exp_a[3] = 32'h200;
    exp_v[0] = 2'b01;   exp_v[1] = 2'b10;   exp_v[2] = 2'b01;   exp_v[3] = 2'b10;
    do_reset();
    req_v_i = 2'b11; m_ready_and_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if ({m_addr_o, req_ready_and_o} !== {exp_a[i], exp_v[i]}) begin bad++; $display("FAIL cont_grant%0d got a=%h r=%b exp a=%h r=%b", i, m_addr_o, req_ready_and_o, exp_a[i], exp_v[i]); end
      @(negedge clk_i);
    end
    req_v_i = 2'b00; m_v_i = 1'b1;
    total++; if (outstanding_o !== 3'd4) begin bad++; $display("FAIL cont_cnt got=%0d exp=4", outstanding_o); end
    for (int i = 0; i < 4; i++) begin
      m_data_i = 32'h10 + i;
      #1;
      total++; if ({resp_v_o, resp_data_o} !== {exp_v[i], 32'h10 + i}) begin bad++; $display("FAIL cont_resp%0d got v=%b d=%h exp v=%b", i, resp_v_o, resp_data_o, exp_v[i]); end
      @(negedge clk_i);
    end
    m_v_i = 1'b0;
    total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL cont_drain got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_grant_lock();
    do_reset();
    req_v_i = 2'b11; m_ready_and_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({m_v_o, m_addr_o, req_ready_and_o} !== {1'b1, 32'h100, 2'b00}) begin bad++; $display("FAIL lock_hold%0d got v=%b a=%h r=%b exp v=1 a=100 r=00", i, m_v_o, m_addr_o, req_ready_and_o); end
      @(negedge clk_i);
    end
    m_ready_and_i = 1'b1;
    #1;
    total++; if ({m_addr_o, req_ready_and_o} !== {32'h100, 2'b01}) begin bad++; $display("FAIL lock_issue0 got a=%h r=%b exp a=100 r=01", m_addr_o, req_ready_and_o); end
    @(negedge clk_i);
    req_v_i = 2'b10;
    #1;
    total++; if ({m_addr_o, req_ready_and_o} !== {32'h200, 2'b10}) begin bad++; $display("FAIL lock_issue1 got a=%h r=%b exp a=200 r=10", m_addr_o, req_ready_and_o); end
    @(negedge clk_i);
    req_v_i = 2'b00;
    total++; if ({outstanding_o, error_o} !== {3'd2, 1'b0}) begin bad++; $display("FAIL lock_cnt got c=%0d e=%b exp c=2 e=0", outstanding_o, error_o); end
  endtask

  task automatic test_full();
    do_reset();
    req_v_i = 2'b01; m_ready_and_i = 1'b1;
    repeat (4) @(negedge clk_i);
    #1;
    total++; if ({outstanding_o, m_v_o, req_ready_and_o} !== {3'd4, 1'b0, 2'b00}) begin bad++; $display("FAIL full_block got c=%0d v=%b r=%b exp c=4 v=0 r=00", outstanding_o, m_v_o, req_ready_and_o); end
    m_v_i = 1'b1; resp_ready_and_i = 2'b01;
    #1;
    total++; if ({m_ready_and_o, m_v_o} !== 2'b10) begin bad++; $display("FAIL full_pop_cycle got pr=%b v=%b exp pr=1 v=0", m_ready_and_o, m_v_o); end
    @(negedge clk_i);
    m_v_i = 1'b0;
    #1;
    total++; if ({outstanding_o, m_v_o, req_ready_and_o} !== {3'd3, 1'b1, 2'b01}) begin bad++; $display("FAIL full_reissue got c=%0d v=%b r=%b exp c=3 v=1 r=01", outstanding_o, m_v_o, req_ready_and_o); end
    @(posedge clk_i); #1;
    total++; if (outstanding_o !== 3'd4) begin bad++; $display("FAIL full_refill got=%0d exp=4", outstanding_o); end
  endtask

  task automatic test_resp_backpressure();
    do_reset();
    m_ready_and_i = 1'b1; req_v_i = 2'b01;
    @(negedge clk_i); req_v_i = 2'b10;
    @(negedge clk_i); req_v_i = 2'b00; m_v_i = 1'b1; resp_ready_and_i = 2'b11;
    @(negedge clk_i); resp_ready_and_i = 2'b01;
    #1;
    total++; if ({resp_v_o, m_ready_and_o} !== {2'b10, 1'b0}) begin bad++; $display("FAIL bp_stall got v=%b r=%b exp v=10 r=0", resp_v_o, m_ready_and_o); end
    @(negedge clk_i);
    total++; if (outstanding_o !== 3'd1) begin bad++; $display("FAIL bp_cnt got=%0d exp=1", outstanding_o); end
    resp_ready_and_i = 2'b10;
    #1;
    total++; if (m_ready_and_o !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", m_ready_and_o); end
    @(negedge clk_i); m_v_i = 1'b0;
    total++; if ({outstanding_o, error_o} !== {3'd0, 1'b0}) begin bad++; $display("FAIL bp_drain got c=%0d e=%b exp c=0 e=0", outstanding_o, error_o); end
  endtask

  task automatic test_lock_drop();
    do_reset();
    req_v_i = 2'b11; m_ready_and_i = 1'b0;
    @(negedge clk_i);
    req_v_i = 2'b10;
    total++; if (error_o !== 1'b0) begin bad++; $display("FAIL drop_pre got=%b exp=0", error_o); end
    @(negedge clk_i);
    m_ready_and_i = 1'b1;
    #1;
    total++; if ({error_o, req_ready_and_o, m_addr_o} !== {1'b1, 2'b10, 32'h200}) begin bad++; $display("FAIL drop_err got e=%b r=%b a=%h exp e=1 r=10 a=200", error_o, req_ready_and_o, m_addr_o); end
  endtask

  task automatic test_errors();
    do_reset();
    m_v_i = 1'b1;
    #1;
    total++; if ({m_ready_and_o, resp_v_o} !== 3'b000) begin bad++; $display("FAIL err_noconsume got=%b exp=000", {m_ready_and_o, resp_v_o}); end
    @(negedge clk_i); m_v_i = 1'b0;
    total++; if (error_o !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", error_o); end
    @(negedge clk_i);
    total++; if (error_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", error_o); end
    req_v_i = 2'b10; m_ready_and_i = 1'b1;
    @(negedge clk_i);
    req_v_i = 2'b00;
    #2 reset_n_i = 1'b0;
    #1;
    total++; if ({outstanding_o, error_o} !== {3'd0, 1'b0}) begin bad++; $display("FAIL async_rst got c=%0d e=%b exp c=0 e=0", outstanding_o, error_o); end
    @(negedge clk_i);
    reset_n_i = 1'b1; req_v_i = 2'b11;
    #1;
    total++; if ({m_addr_o, req_ready_and_o} !== {32'h100, 2'b01}) begin bad++; $display("FAIL rst_first got a=%h r=%b exp a=100 r=01", m_addr_o, req_ready_and_o); end
  endtask

  initial begin
    idle_inputs();
    reset_n_i = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_grant_lock();
    test_full();
    test_resp_backpressure();
    test_lock_drop();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
